// File: rtl/spi_platform_designer_timer_master.sv
// spi_platform_designer_timer_master
//
// Avalon-MM initiator that does the interval-timer housekeeping for the SPI
// control logic. It loads a 32-bit period, starts the timer (one-shot or
// continuous, interrupt enabled), clears each timeout, stops the timer on
// request and reads back counter snapshots.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/ready     start handshake (ready only in IDLE)
//   cmd_period          32-bit period loaded into the timer
//   cmd_continuous      1 = continuous, 0 = one-shot
//   stop_req, snap_req  single-cycle request pulses, held as pending flags
//   tick, tick_count    one pulse / running count per serviced timeout
//   snap_valid/value    single-cycle pulse with the captured 32-bit snapshot
//   busy                FSM not in IDLE
//   avm_*               Avalon-MM master to the timer (16-bit, 3-bit address,
//                       read latency 1, no waitrequest)
//   timer_irq           level interrupt from the timer
module spi_platform_designer_timer_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        stop_req,
  input  logic        snap_req,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        busy,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] WR_PL     = 4'd1;
  localparam logic [3:0] WR_PH     = 4'd2;
  localparam logic [3:0] WR_CTL    = 4'd3;
  localparam logic [3:0] RUN       = 4'd4;
  localparam logic [3:0] CLR_TO    = 4'd5;
  localparam logic [3:0] WR_STOP   = 4'd6;
  localparam logic [3:0] SNAP_WR   = 4'd7;
  localparam logic [3:0] SNAP_RDL  = 4'd8;
  localparam logic [3:0] SNAP_RDH  = 4'd9;
  localparam logic [3:0] SNAP_DONE = 4'd10;

  // Timer register map
  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERL    = 3'd2;
  localparam logic [2:0] A_PERH    = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  logic [3:0]  state_reg, state_next;
  logic [15:0] period_hi_reg;
  logic        cont_reg;
  logic        stop_pend_reg;
  logic        snap_pend_reg;
  logic        snap_from_run_reg;

  logic        cs_next;
  logic        write_n_next;
  logic [2:0]  addr_next;
  logic [15:0] wdata_next;

  logic cmd_fire;
  assign cmd_fire = cmd_valid & cmd_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire)           state_next = WR_PL;
        else if (snap_pend_reg) state_next = SNAP_WR;
      end
      WR_PL:   state_next = WR_PH;
      WR_PH:   state_next = WR_CTL;
      WR_CTL:  state_next = RUN;
      RUN: begin
        if (timer_irq)          state_next = CLR_TO;
        else if (stop_pend_reg) state_next = WR_STOP;
        else if (snap_pend_reg) state_next = SNAP_WR;
      end
      CLR_TO:    state_next = cont_reg ? RUN : IDLE;
      WR_STOP:   state_next = IDLE;
      SNAP_WR:   state_next = SNAP_RDL;
      SNAP_RDL:  state_next = SNAP_RDH;
      SNAP_RDH:  state_next = SNAP_DONE;
      SNAP_DONE: state_next = snap_from_run_reg ? RUN : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bus signals are decoded from the state being entered so that the
  // registered outputs line up with the state that owns the transfer.
  // The low period half is taken straight from the command port because
  // WR_PL is entered on the same edge that accepts the command.
  always_comb begin
    cs_next      = 1'b0;
    write_n_next = 1'b1;
    addr_next    = A_STATUS;
    wdata_next   = 16'h0000;
    case (state_next)
      WR_PL: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_PERL;
        wdata_next = cmd_period[15:0];
      end
      WR_PH: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_PERH;
        wdata_next = period_hi_reg;
      end
      WR_CTL: begin
        // {start, cont, ito}
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_CONTROL;
        wdata_next = {13'd0, 1'b1, cont_reg, 1'b1};
      end
      CLR_TO: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_STATUS;
      end
      WR_STOP: begin
        // {stop, start=0, cont, ito}
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_CONTROL;
        wdata_next = {12'd0, 1'b1, 1'b0, cont_reg, 1'b1};
      end
      SNAP_WR: begin
        cs_next = 1'b1; write_n_next = 1'b0; addr_next = A_SNAPL;
      end
      SNAP_RDL: begin
        cs_next = 1'b1; addr_next = A_SNAPL;
      end
      SNAP_RDH: begin
        cs_next = 1'b1; addr_next = A_SNAPH;
      end
      default: begin
        cs_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      period_hi_reg     <= 16'h0000;
      cont_reg          <= 1'b0;
      stop_pend_reg     <= 1'b0;
      snap_pend_reg     <= 1'b0;
      snap_from_run_reg <= 1'b0;
      cmd_ready         <= 1'b0;
      busy              <= 1'b0;
      tick              <= 1'b0;
      tick_count        <= 16'h0000;
      snap_valid        <= 1'b0;
      snap_value        <= 32'h0000_0000;
      avm_chipselect    <= 1'b0;
      avm_write_n       <= 1'b1;
      avm_address       <= 3'd0;
      avm_writedata     <= 16'h0000;
    end else begin
      state_reg      <= state_next;
      cmd_ready      <= (state_next == IDLE);
      busy           <= (state_next != IDLE);
      avm_chipselect <= cs_next;
      avm_write_n    <= write_n_next;
      avm_address    <= addr_next;
      avm_writedata  <= wdata_next;
      tick           <= (state_next == CLR_TO);
      snap_valid     <= (state_reg == SNAP_DONE);

      if (state_reg == CLR_TO) tick_count <= tick_count + 16'd1;

      // Read data arrives one cycle after the address: the low half
      // (addressed in SNAP_RDL) is on the bus during SNAP_RDH, the high
      // half during SNAP_DONE.
      if (state_reg == SNAP_RDH)  snap_value[15:0]  <= avm_readdata;
      if (state_reg == SNAP_DONE) snap_value[31:16] <= avm_readdata;

      if (cmd_fire) begin
        period_hi_reg <= cmd_period[31:16];
        cont_reg      <= cmd_continuous;
      end

      // A stop while idle has nothing to stop, so it is simply dropped.
      if (state_reg == IDLE || state_reg == WR_STOP) stop_pend_reg <= 1'b0;
      else if (stop_req)                             stop_pend_reg <= 1'b1;

      if (state_reg == SNAP_DONE) snap_pend_reg <= 1'b0;
      else if (snap_req)          snap_pend_reg <= 1'b1;

      if (state_next == SNAP_WR) snap_from_run_reg <= (state_reg == RUN);
    end
  end

endmodule
